float27_to_fixed: RTL and testbench

Sequential converter from the team's 27-bit float format (1-bit sign, 8-bit exponent with bias 127, 18-bit explicit normalized mantissa, value = (-1)^S × (M/2^18) × 2^(E−127)) to signed two's-complement fixed point. It is the output end of the float datapath: `summ` and its siblings produce float27 words, and this block turns them back into fixed-point values for pixel/iteration logic. It uses a start/done handshake and an iterative one-bit-per-cycle shifter, so latency depends on the exponent.

---
 rtl/float27_pkg.sv | 19 +
 rtl/float27_to_fixed_if.sv | 25 ++
 rtl/float27_unpack.sv | 25 ++
 rtl/float27_to_fixed.sv | 165 ++++++++++++++++
 tb/tb_float27_to_fixed.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/float27_pkg.sv
// Shared float27 field widths, exponent bias and converter FSM states.
package float27_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 18;
  localparam int FLOAT_W  = 27;
  localparam int EXP_BIAS = 127;

  // Width of the signed shift count k; wide enough for any exponent/FRAC_BITS mix.
  localparam int K_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/float27_to_fixed_if.sv
// Start/done handshake bundle for the float27 to fixed-point converter.
interface float27_to_fixed_if
  import float27_pkg::*;
#(
  parameter int W = 32
);

  logic               start;
  logic [FLOAT_W-1:0] input_a;
  logic [W-1:0]       output_q;
  logic               overflow;
  logic               busy;
  logic               done;

  modport master (
    output start, input_a,
    input  output_q, overflow, busy, done
  );

  modport slave (
    input  start, input_a,
    output output_q, overflow, busy, done
  );

endinterface

// File: rtl/float27_unpack.sv
// Combinational float27 field split, zero detect and fixed-point shift count k.
module float27_unpack
  import float27_pkg::*;
#(
  parameter int FRAC_BITS = 24
) (
  input  logic [FLOAT_W-1:0]   a,
  output logic                 sign,
  output logic [MANT_W-1:0]    mant,
  output logic                 is_zero,
  output logic signed [K_W-1:0] k
);

  // k = E - (bias + mantissa width) + FRAC_BITS; positive means shift left.
  localparam logic signed [K_W-1:0] K_OFF = K_W'(FRAC_BITS - EXP_BIAS - MANT_W);

  logic [EXP_W-1:0] exp_f;

  assign sign    = a[FLOAT_W-1];
  assign exp_f   = a[FLOAT_W-SIGN_W-1 -: EXP_W];
  assign mant    = a[MANT_W-1:0];
  assign is_zero = (exp_f == '0);
  assign k       = $signed({{(K_W-EXP_W){1'b0}}, exp_f}) + K_OFF;

endmodule

// File: rtl/float27_to_fixed.sv
// Iterative float27 -> signed fixed-point converter, one shift per cycle.
// Define FLOAT27_ROUND_EN for round-half-away-from-zero; otherwise truncates.
module float27_to_fixed
  import float27_pkg::*;
#(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 24
) (
  input  logic              clk,
  input  logic              reset,
  float27_to_fixed_if.slave bus
);

  localparam int W     = INT_BITS + FRAC_BITS;
  localparam int CNT_W = $clog2(W);
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [K_W-1:0] K_MIN = K_W'(-(MANT_W + 1));
  localparam logic signed [K_W-1:0] N_MAX = K_W'(W - 1);

  logic                  u_sign;
  logic [MANT_W-1:0]     u_mant;
  logic                  u_zero;
  logic signed [K_W-1:0] u_k;

  float27_unpack #(.FRAC_BITS(FRAC_BITS)) u_unpack (
    .a       (bus.input_a),
    .sign    (u_sign),
    .mant    (u_mant),
    .is_zero (u_zero),
    .k       (u_k)
  );

  logic                  k_neg;
  logic signed [K_W-1:0] k_abs;
  logic                  kill;
  logic [CNT_W-1:0]      n_load;

  assign k_neg  = u_k[K_W-1];
  assign k_abs  = k_neg ? -u_k : u_k;
  assign kill   = u_zero || (u_k < K_MIN);
  assign n_load = (k_abs > N_MAX) ? CNT_W'(W - 1) : k_abs[CNT_W-1:0];

  state_t           state_q, state_d;
  logic [W-1:0]     mag_q, mag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             right_q, right_d;
  logic             ovf_q, ovf_d;
  logic [W-1:0]     result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             round_inc;
  logic [W-1:0]     mag_rnd;

`ifdef FLOAT27_ROUND_EN
  logic guard_q, guard_d;
  assign round_inc = right_q & guard_q;
`else
  assign round_inc = 1'b0;
`endif

  assign mag_rnd = mag_q + W'(round_inc);

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    right_d    = right_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef FLOAT27_ROUND_EN
    guard_d    = guard_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sign_d  = u_sign;
          right_d = k_neg;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef FLOAT27_ROUND_EN
          guard_d = 1'b0;
`endif
          mag_d   = kill ? '0 : W'(u_mant);
          cnt_d   = kill ? '0 : n_load;
          state_d = (!kill && n_load != '0) ? ST_SHIFT : ST_FINISH;
        end
      end
      ST_SHIFT: begin
        if (right_q) begin
`ifdef FLOAT27_ROUND_EN
          guard_d = mag_q[0];
`endif
          mag_d = mag_q >> 1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FINISH;
        end else if (mag_q[W-2]) begin
          // Another left shift would reach the sign position: saturate now.
          ovf_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (ovf_q) begin
          result_d   = sign_q ? -SAT_POS : SAT_POS;
          overflow_d = 1'b1;
        end else begin
          result_d   = sign_q ? -mag_rnd : mag_rnd;
          overflow_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mag_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      right_q    <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FLOAT27_ROUND_EN
      guard_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      right_q    <= right_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef FLOAT27_ROUND_EN
      guard_q    <= guard_d;
`endif
    end
  end

  assign bus.output_q = result_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_float27_to_fixed.sv
// Directed-vector bench for float27_to_fixed at default widths (Q8.24),
// plus held-start and mid-conversion reset sequences.
module tb_float27_to_fixed;

`ifdef FLOAT27_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  float27_to_fixed_if #(.W(32)) bus ();

  float27_to_fixed #(.INT_BITS(8), .FRAC_BITS(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [26:0] a;
    logic [31:0] q;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One conversion; input_a is scrambled right after the accept edge.
  task automatic run_conv(input logic [26:0] a, output logic [31:0] res, output logic ovf,
                          output int lat, output logic busy_seen);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.input_a = a;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.input_a = ~a;
    busy_seen   = bus.busy;
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    res = bus.output_q;
    ovf = bus.overflow;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic        ovf;
    logic        bsy;
    int          lat;
    int          dones;

    vecs[0]  = '{27'h1FE0000, 32'h00800000, 1'b0, 7};   // 0.5
    vecs[1]  = '{27'h5FE0000, 32'hFF800000, 1'b0, 7};   // -0.5
    vecs[2]  = '{27'h20A0000, 32'h04000000, 1'b0, 10};  // 4.0
    vecs[3]  = '{27'h2420000, 32'h7FFFFFFF, 1'b1, 15};  // 65536 saturates
    vecs[4]  = '{27'h6420000, 32'h80000001, 1'b1, 15};  // -65536 saturates
    vecs[5]  = '{27'h1E20001, RND ? 32'h00010001 : 32'h00010000, 1'b0, 2};
    vecs[6]  = '{27'h5E20001, RND ? 32'hFFFEFFFF : 32'hFFFF0000, 1'b0, 2};
    vecs[7]  = '{27'h0000000, 32'h00000000, 1'b0, 1};   // +0
    vecs[8]  = '{27'h4000000, 32'h00000000, 1'b0, 1};   // -0
    vecs[9]  = '{27'h0060000, 32'h00000000, 1'b0, 1};   // E=1, k=-120
    vecs[10] = '{27'h2020000, 32'h01000000, 1'b0, 8};   // 1.0
    vecs[11] = '{27'h19BFFFF, 32'h00000000, 1'b0, 20};  // k=-19 shifts all out
    vecs[12] = '{27'h197FFFF, 32'h00000000, 1'b0, 1};   // k=-20 short-cut
    vecs[13] = '{27'h19FFFFF, RND ? 32'h00000001 : 32'h00000000, 1'b0, 19}; // k=-18
    vecs[14] = '{27'h21BFFFF, 32'h7FFFE000, 1'b0, 14};  // k=13 largest fit
    vecs[15] = '{27'h21FFFFF, 32'h7FFFFFFF, 1'b1, 15};  // k=14 overflows
    vecs[16] = '{27'h3FE0000, 32'h7FFFFFFF, 1'b1, 15};  // E=255
    vecs[17] = '{27'h3FC0000, 32'h00000000, 1'b0, 32};  // E=255, M=0: max latency
    vecs[18] = '{27'h6030000, 32'hFE800000, 1'b0, 8};   // -1.5

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.input_a = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_output_q", 64'(bus.output_q), 64'h0);
    chk("reset_overflow", 64'(bus.overflow), 64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    chk("reset_done", 64'(bus.done), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      run_conv(vecs[i].a, res, ovf, lat, bsy);
      $display("vec %0d: a=%07h q=%08h ovf=%0b lat=%0d", i, vecs[i].a, res, ovf, lat);
      chk($sformatf("vec%0d_output_q", i), 64'(res), 64'(vecs[i].q));
      chk($sformatf("vec%0d_overflow", i), 64'(ovf), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy", i), 64'(bsy), 64'h1);
    end

    // start held high: one conversion, then re-accept in the done cycle.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.input_a = 27'h20A0000;
    @(posedge clk);
    #1;
    bus.input_a = 27'h1FE0000;
    chk("held_busy", 64'(bus.busy), 64'h1);
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    $display("held first: q=%08h lat=%0d", bus.output_q, lat);
    chk("held_first_latency", 64'(lat), 64'd10);
    chk("held_first_output_q", 64'(bus.output_q), 64'h04000000);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("held_reaccept_busy", 64'(bus.busy), 64'h1);
    chk("held_reaccept_done_low", 64'(bus.done), 64'h0);
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    $display("held second: q=%08h lat=%0d", bus.output_q, lat);
    chk("held_second_latency", 64'(lat), 64'd7);
    chk("held_second_output_q", 64'(bus.output_q), 64'h00800000);

    // Reset during SHIFT aborts the conversion.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.input_a = 27'h20A0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("abort: q=%08h ovf=%0b busy=%0b done=%0b", bus.output_q, bus.overflow, bus.busy,
             bus.done);
    chk("abort_output_q", 64'(bus.output_q), 64'h0);
    chk("abort_overflow", 64'(bus.overflow), 64'h0);
    chk("abort_busy", 64'(bus.busy), 64'h0);
    chk("abort_done", 64'(bus.done), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'h0);
    run_conv(27'h5FE0000, res, ovf, lat, bsy);
    $display("after abort: q=%08h ovf=%0b lat=%0d", res, ovf, lat);
    chk("after_abort_output_q", 64'(res), 64'hFF800000);
    chk("after_abort_overflow", 64'(ovf), 64'h0);
    chk("after_abort_latency", 64'(lat), 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
